// File: rtl/matrix_multiply_acc.sv
// rtl/matrix_multiply_acc.sv - multi-lane sequential signed matrix multiply with rescale, saturate and accumulate
module matrix_multiply_acc #(
  parameter int N      = 3,
  parameter int Din    = 3,
  parameter int Dout   = 3,
  parameter int WIDTHA = 8,
  parameter int WIDTHB = 8,
  parameter int WIDTHC = WIDTHA + WIDTHB,
  parameter int LANES  = 1,
  parameter int SHIFTW = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         START,
  input  logic                         ACCUMULATE,
  input  logic [SHIFTW-1:0]            SHIFT,
  input  logic [N*Din*WIDTHA-1:0]      a,
  input  logic [Din*Dout*WIDTHB-1:0]   b,
  output logic [N*Dout*WIDTHC-1:0]     c,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int ACCW = WIDTHA + WIDTHB + $clog2(Din) + 1;
  localparam int G    = Dout / LANES;
  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int KW   = (Din > 1) ? $clog2(Din) : 1;

  localparam logic [IW-1:0] I_LAST = IW'(N - 1);
  localparam logic [GW-1:0] G_LAST = GW'(G - 1);
  localparam logic [KW-1:0] K_LAST = KW'(Din - 1);

  // Saturation bounds expressed in the widened write-back arithmetic
  localparam logic signed [ACCW:0] MAXC = (ACCW+1)'({1'b0, {(WIDTHC-1){1'b1}}});
  localparam logic signed [ACCW:0] MINC = ~MAXC;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t state, state_nx;

  logic [N*Din*WIDTHA-1:0]    a_q;
  logic [Din*Dout*WIDTHB-1:0] b_q;
  logic                       acc_mode;
  logic [SHIFTW-1:0]          shift_q;
  logic [IW-1:0]              i_idx;
  logic [GW-1:0]              g_idx;
  logic [KW-1:0]              k_idx;
  logic signed [ACCW-1:0]     acc    [LANES];
  logic signed [ACCW-1:0]     sum_nx [LANES];
  logic signed [WIDTHC-1:0]   c_nx   [LANES];
  logic                       k_last;
  logic                       last_write;

  logic signed [WIDTHA-1:0]        a_el;
  logic signed [WIDTHB-1:0]        b_el;
  logic signed [WIDTHA+WIDTHB-1:0] prod;
  logic signed [ACCW:0]            ext;
  logic signed [ACCW:0]            rnd;
  logic signed [ACCW:0]            rsh;
  logic signed [ACCW:0]            vsum;
  logic signed [WIDTHC-1:0]        c_old;
  int                              col;

  assign k_last     = (k_idx == K_LAST);
  assign last_write = k_last && (g_idx == G_LAST) && (i_idx == I_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and status outputs; DONE holds until START is released
  always_comb begin
    state_nx = state;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state)
      S_IDLE: if (START) state_nx = S_MAC;
      S_MAC: begin
        BUSY = 1'b1;
        if (last_write) state_nx = S_DONE;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (!START) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-lane MAC step plus rounding shift, optional accumulate and saturation
  always_comb begin
    a_el = '0;
    b_el = '0;
    prod = '0;
    ext  = '0;
    rnd  = '0;
    rsh  = '0;
    vsum = '0;
    c_old = '0;
    col  = 0;
    for (int l = 0; l < LANES; l++) begin
      col   = int'(g_idx) * LANES + l;
      a_el  = a_q[(int'(i_idx) * Din + int'(k_idx)) * WIDTHA +: WIDTHA];
      b_el  = b_q[(int'(k_idx) * Dout + col) * WIDTHB +: WIDTHB];
      prod  = a_el * b_el;
      sum_nx[l] = acc[l] + ACCW'(prod);
      ext   = (ACCW+1)'(sum_nx[l]);
      // A shift at least as wide as the accumulator always rounds to zero
      if (shift_q == '0) begin
        rsh = ext;
      end else if (int'(shift_q) >= ACCW) begin
        rsh = '0;
      end else begin
        rnd = (ACCW+1)'(1) << (shift_q - SHIFTW'(1));
        rsh = (ext + rnd) >>> shift_q;
      end
      c_old = c[(int'(i_idx) * Dout + col) * WIDTHC +: WIDTHC];
      vsum  = rsh + (acc_mode ? (ACCW+1)'(c_old) : (ACCW+1)'(0));
      if (vsum > MAXC)      c_nx[l] = MAXC[WIDTHC-1:0];
      else if (vsum < MINC) c_nx[l] = MINC[WIDTHC-1:0];
      else                  c_nx[l] = vsum[WIDTHC-1:0];
    end
  end

  // Operand capture, loop indices, accumulators and result write-back
  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_mode <= 1'b0;
      shift_q  <= '0;
      i_idx    <= '0;
      g_idx    <= '0;
      k_idx    <= '0;
      c        <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            a_q      <= a;
            b_q      <= b;
            acc_mode <= ACCUMULATE;
            shift_q  <= SHIFT;
            i_idx    <= '0;
            g_idx    <= '0;
            k_idx    <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
          end
        end
        S_MAC: begin
          if (k_last) begin
            for (int l = 0; l < LANES; l++) begin
              c[(int'(i_idx) * Dout + int'(g_idx) * LANES + l) * WIDTHC +: WIDTHC] <= c_nx[l];
              acc[l] <= '0;
            end
            k_idx <= '0;
            if (g_idx == G_LAST) begin
              g_idx <= '0;
              i_idx <= (i_idx == I_LAST) ? '0 : i_idx + 1'b1;
            end else begin
              g_idx <= g_idx + 1'b1;
            end
          end else begin
            for (int l = 0; l < LANES; l++) acc[l] <= sum_nx[l];
            k_idx <= k_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
